// File: rtl/trash_compactor_accum.sv
// Column-problem evaluator: gathers BCD operand beats, decodes them, folds each problem
// (add or multiply) in a NUM_LINES-1 stage pipeline and sums problem results into a batch total.
module trash_compactor_accum #(
  parameter int NUM_LINES = 4,
  parameter int DIGITS    = 4,
  parameter int BUS_W     = 32,
  parameter int RESULT_W  = 64,
  parameter int CNT_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BUS_W-1:0]    data_in,
  input  logic                op,
  input  logic                last_in,
  input  logic                valid_in,
  output logic                ready,
  output logic                finished,
  output logic [RESULT_W-1:0] result,
  output logic [CNT_W-1:0]    problem_count,
  output logic                overflow
);

  localparam int FIELD_W = DIGITS * 4;
  localparam int PROB_W  = NUM_LINES * FIELD_W;
  localparam int BEATS   = PROB_W / BUS_W;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int STAGES  = NUM_LINES - 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state, w_state_nxt;
  logic   w_accept, w_final_beat, w_batch_start;

  // Blank (>9) nibbles are skipped; the remaining digits form the decimal value MS first.
  function automatic logic [RESULT_W-1:0] bcd_decode(input logic [FIELD_W-1:0] f);
    logic [RESULT_W-1:0] v;
    logic [3:0]          nib;
    v = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nib = f[k*4 +: 4];
      if (nib <= 4'd9) v = v * RESULT_W'(10) + RESULT_W'(nib);
    end
    return v;
  endfunction

  // ---------------- beat collection / complete flag ----------------
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [PROB_W-1:0] r_prob_buf;
  logic              r_op_buf, r_c_last, r_c_valid;

  assign ready        = (r_state != S_DRAIN);
  assign w_accept     = valid_in && ready;
  assign w_final_beat = (r_beat_cnt == BEAT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
      r_c_valid  <= 1'b0;
    end else begin
      r_c_valid <= w_accept && w_final_beat;
      if (w_accept) r_beat_cnt <= w_final_beat ? '0 : r_beat_cnt + BEAT_W'(1);
    end
  end

  // NOTE: payload registers carry no reset; only their valid flags need a defined value.
  // The buffer doubles as the complete-problem register: decode samples it on the edge
  // after the final beat, before the next problem's beat 0 lands.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_prob_buf[int'(r_beat_cnt)*BUS_W +: BUS_W] <= data_in;
      if (r_beat_cnt == '0) r_op_buf <= op;
      if (w_final_beat)     r_c_last <= last_in;
    end
  end

  // ---------------- decode (index 0) and fold stages (1..STAGES) ----------------
  logic                r_p_valid [STAGES+1];
  logic [RESULT_W-1:0] r_p_acc   [STAGES+1];
  logic                r_p_ovf   [STAGES+1];
  logic                r_p_last  [STAGES+1];
  logic                r_p_op    [STAGES];
  logic [RESULT_W-1:0] r_p_opnd  [STAGES][NUM_LINES];

  always_ff @(posedge clk) begin
    if (rst) r_p_valid[0] <= 1'b0;
    else     r_p_valid[0] <= r_c_valid;
  end

  always_ff @(posedge clk) begin
    r_p_acc[0]  <= bcd_decode(r_prob_buf[0 +: FIELD_W]);
    r_p_ovf[0]  <= 1'b0;
    r_p_last[0] <= r_c_last;
    r_p_op[0]   <= r_op_buf;
    for (int i = 0; i < NUM_LINES; i++)
      r_p_opnd[0][i] <= bcd_decode(r_prob_buf[i*FIELD_W +: FIELD_W]);
  end

  for (genvar j = 1; j <= STAGES; j++) begin : g_fold
    logic [RESULT_W-1:0]   w_opnd;
    logic [2*RESULT_W-1:0] w_prod;
    logic [RESULT_W:0]     w_sum;

    assign w_opnd = r_p_opnd[j-1][j];
    assign w_prod = {{RESULT_W{1'b0}}, r_p_acc[j-1]} * {{RESULT_W{1'b0}}, w_opnd};
    assign w_sum  = {1'b0, r_p_acc[j-1]} + {1'b0, w_opnd};

    always_ff @(posedge clk) begin
      if (rst) r_p_valid[j] <= 1'b0;
      else     r_p_valid[j] <= r_p_valid[j-1];
    end

    always_ff @(posedge clk) begin
      r_p_last[j] <= r_p_last[j-1];
      if (r_p_op[j-1]) begin
        r_p_acc[j] <= w_sum[RESULT_W-1:0];
        r_p_ovf[j] <= r_p_ovf[j-1] | w_sum[RESULT_W];
      end else begin
        r_p_acc[j] <= w_prod[RESULT_W-1:0];
        r_p_ovf[j] <= r_p_ovf[j-1] | (|w_prod[2*RESULT_W-1:RESULT_W]);
      end
    end

    if (j < STAGES) begin : g_carry
      always_ff @(posedge clk) begin
        r_p_op[j]   <= r_p_op[j-1];
        r_p_opnd[j] <= r_p_opnd[j-1];
      end
    end
  end

  // ---------------- batch accumulation ----------------
  logic                r_finished, r_ovf;
  logic [RESULT_W-1:0] r_acc, r_result;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_a_valid, w_a_last;
  logic [RESULT_W:0]   w_batch_sum;

  assign w_a_valid   = r_p_valid[STAGES];
  assign w_a_last    = r_p_last[STAGES];
  assign w_batch_sum = {1'b0, r_acc} + {1'b0, r_p_acc[STAGES]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_result   <= '0;
      r_finished <= 1'b0;
    end else if (w_batch_start) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_finished <= 1'b0;
    end else if (w_a_valid) begin
      r_acc <= w_batch_sum[RESULT_W-1:0];
      r_cnt <= r_cnt + CNT_W'(1);
      r_ovf <= r_ovf | r_p_ovf[STAGES] | w_batch_sum[RESULT_W];
      if (w_a_last) begin
        r_result   <= w_batch_sum[RESULT_W-1:0];
        r_finished <= 1'b1;
      end
    end
  end

  assign finished      = r_finished;
  assign result        = r_result;
  assign problem_count = r_cnt;
  assign overflow      = r_ovf;

  // ---------------- batch FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_batch_start = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_batch_start = 1'b1;
          w_state_nxt   = (w_final_beat && last_in) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN:   if (w_accept && w_final_beat && last_in) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_a_valid && w_a_last) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
